// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings, default widths and the ID/EX payload record.
// The payload field widths follow XLEN/RADDR_W declared here.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_OR   = 4'b1100;
    localparam logic [3:0] ALU_AND  = 4'b1110;

    // Source addresses and use_imm travel with the entry so held entries can snoop writeback.
    typedef struct packed {
        logic [XLEN-1:0]    a;
        logic [XLEN-1:0]    b;
        logic [3:0]         sel;
        logic [RADDR_W-1:0] rd;
        logic               we;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
        logic               use_imm;
    } stage_payload_t;

    localparam stage_payload_t PAYLOAD_RESET = '0;

endpackage

// File: rtl/fwd_mux.sv
// Priority operand select for one source register: EX/MEM, then MEM/WB, then register file.
// Bypassing is present only when FWD_EN is defined; otherwise the register file value passes through.
module fwd_mux #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]    rf_data,
    input  logic               mem_we,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_data,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic [XLEN-1:0]    fwd_data
);

`ifdef FWD_EN
    always_comb begin
        fwd_data = rf_data;
        if (mem_we && (mem_rd == rs_addr) && (rs_addr != '0)) begin
            fwd_data = mem_data;
        end else if (wb_we && (wb_rd == rs_addr) && (rs_addr != '0)) begin
            fwd_data = wb_data;
        end
    end
`else
    logic unused_fwd;
    assign fwd_data   = rf_data;
    assign unused_fwd = ^{rs_addr, mem_we, mem_rd, mem_data, wb_we, wb_rd, wb_data};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX register with a 2-entry skid buffer, operand bypassing and held-entry writeback snoop.
// Define FWD_EN to enable bypassing and snoop; without it the hazard unit must stall instead.
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int XLEN    = alu_pkg::XLEN,
    parameter int RADDR_W = alu_pkg::RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [RADDR_W-1:0] in_rs1_addr,
    input  logic [RADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]    in_rs1_data,
    input  logic [XLEN-1:0]    in_rs2_data,
    input  logic [XLEN-1:0]    in_imm,
    input  logic               in_use_imm,
    input  logic [3:0]         in_sel,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_we,
    input  logic               mem_we,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic [XLEN-1:0]    mem_data,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    alu_a,
    output logic [XLEN-1:0]    alu_b,
    output logic [3:0]         alu_sel,
    output logic [RADDR_W-1:0] out_rd,
    output logic               out_we
);

    stage_payload_t  main_q, main_d, skid_q, skid_d;
    stage_payload_t  main_held, skid_held, in_pl;
    logic            out_valid_q, out_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic            in_fire, out_fire;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
        .rs_addr(in_rs1_addr), .rf_data(in_rs1_data),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .fwd_data(fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
        .rs_addr(in_rs2_addr), .rf_data(in_rs2_data),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .fwd_data(fwd_rs2)
    );

    always_comb begin
        in_pl         = PAYLOAD_RESET;
        in_pl.a       = fwd_rs1;
        in_pl.b       = in_use_imm ? in_imm : fwd_rs2;
        in_pl.sel     = in_sel;
        in_pl.rd      = in_rd;
        in_pl.we      = in_we;
        in_pl.rs1     = in_rs1_addr;
        in_pl.rs2     = in_rs2_addr;
        in_pl.use_imm = in_use_imm;
    end

`ifdef FWD_EN
    // A waiting entry would otherwise miss a writeback that retires while it is stalled.
    function automatic stage_payload_t snoop(input stage_payload_t e, input logic we,
                                             input logic [RADDR_W-1:0] rd,
                                             input logic [XLEN-1:0] data);
        stage_payload_t r;
        r = e;
        if (we && (rd != '0)) begin
            if (e.rs1 == rd) r.a = data;
            if (!e.use_imm && (e.rs2 == rd)) r.b = data;
        end
        return r;
    endfunction

    always_comb begin
        main_held = main_q;
        skid_held = skid_q;
        if (out_valid_q)  main_held = snoop(main_q, wb_we, wb_rd, wb_data);
        if (skid_valid_q) skid_held = snoop(skid_q, wb_we, wb_rd, wb_data);
    end
`else
    logic unused_held;
    assign main_held   = main_q;
    assign skid_held   = skid_q;
    assign unused_held = ^{main_q.rs1, main_q.rs2, main_q.use_imm};
`endif

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        main_d       = main_held;
        skid_d       = skid_held;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_d       = skid_held;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                main_d      = in_pl;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d       = in_pl;
            skid_valid_d = 1'b1;
        end
        // Redirect wins over any transfer decided above.
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q       <= PAYLOAD_RESET;
            skid_q       <= PAYLOAD_RESET;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = out_valid_q;
    assign alu_a     = main_q.a;
    assign alu_b     = main_q.b;
    assign alu_sel   = main_q.sel;
    assign out_rd    = main_q.rd;
    assign out_we    = out_valid_q & main_q.we;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: queue-based reference model plus directed literal checks.
// Expectations follow FWD_EN when the bench is compiled with it.
module tb_id_ex_stage;
    import alu_pkg::*;

`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd, mem_rd, wb_rd, out_rd;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm, mem_data, wb_data, alu_a, alu_b;
    logic        in_use_imm, in_we, mem_we, wb_we, out_valid, out_ready, out_we;
    logic [3:0]  in_sel, alu_sel;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_sel(in_sel),
        .in_rd(in_rd), .in_we(in_we),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .out_rd(out_rd), .out_we(out_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        ui;
    } ent_t;

    ent_t mq[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwdModel(input logic [4:0] rs, input logic [31:0] rf);
        if (FWD && rs != 5'd0 && mem_we && mem_rd == rs) return mem_data;
        if (FWD && rs != 5'd0 && wb_we && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    // Reference: an in-order queue of at most two instructions; head is what the ALU sees.
    always @(posedge clk) begin : model
        ent_t e;
        bit   rdy;
        if (rst || flush) begin
            mq.delete();
        end else begin
            rdy = (mq.size() < 2);
            if (FWD && wb_we && wb_rd != 5'd0) begin
                foreach (mq[i]) begin
                    if (mq[i].rs1 == wb_rd) mq[i].a = wb_data;
                    if (!mq[i].ui && mq[i].rs2 == wb_rd) mq[i].b = wb_data;
                end
            end
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && rdy) begin
                e.a   = fwdModel(in_rs1_addr, in_rs1_data);
                e.b   = in_use_imm ? in_imm : fwdModel(in_rs2_addr, in_rs2_data);
                e.sel = in_sel;
                e.rd  = in_rd;
                e.we  = in_we;
                e.rs1 = in_rs1_addr;
                e.rs2 = in_rs2_addr;
                e.ui  = in_use_imm;
                mq.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            checkOutput("in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
            checkOutput("out_we", {31'd0, out_we}, {31'd0, (mq.size() > 0) ? mq[0].we : 1'b0});
            if (mq.size() > 0) begin
                checkOutput("alu_a", alu_a, mq[0].a);
                checkOutput("alu_b", alu_b, mq[0].b);
                checkOutput("alu_sel", {28'd0, alu_sel}, {28'd0, mq[0].sel});
                checkOutput("out_rd", {27'd0, out_rd}, {27'd0, mq[0].rd});
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [31:0] imm, input logic ui, input logic [3:0] sel,
                                 input logic [4:0] rd, input logic ordy);
        in_valid    = v;
        in_rs1_addr = rs1;
        in_rs2_addr = rs2;
        in_rs1_data = d1;
        in_rs2_data = d2;
        in_imm      = imm;
        in_use_imm  = ui;
        in_sel      = sel;
        in_rd       = rd;
        in_we       = v;
        out_ready   = ordy;
        @(negedge clk);
    endtask

    task automatic idleCycle(input logic ordy);
        applyStimulus(1'b0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, ALU_ADD, 5'd0, ordy);
    endtask

    task automatic checkResetPayload();
        checkOutput("rst out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("rst alu_a", alu_a, 32'd0);
        checkOutput("rst alu_b", alu_b, 32'd0);
        checkOutput("rst alu_sel", {28'd0, alu_sel}, 32'd0);
        checkOutput("rst out_rd", {27'd0, out_rd}, 32'd0);
        checkOutput("rst out_we", {31'd0, out_we}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        mem_we = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        idleCycle(1'b1);
        idleCycle(1'b1);
        checkResetPayload();
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Back-to-back add then sub
        applyStimulus(1'b1, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 1'b0, ALU_ADD, 5'd5, 1'b1);
        checkOutput("b2b a0", alu_a, 32'd5);
        checkOutput("b2b b0", alu_b, 32'd7);
        checkOutput("b2b sel0", {28'd0, alu_sel}, {28'd0, ALU_ADD});
        applyStimulus(1'b1, 5'd1, 5'd2, 32'd10, 32'd3, 32'd0, 1'b0, ALU_SUB, 5'd6, 1'b1);
        checkOutput("b2b a1", alu_a, 32'd10);
        checkOutput("b2b b1", alu_b, 32'd3);
        checkOutput("b2b sel1", {28'd0, alu_sel}, {28'd0, ALU_SUB});
        checkOutput("b2b ready", {31'd0, in_ready}, 32'd1);
        idleCycle(1'b1);

        // Forwarding priority
        mem_we = 1'b1; mem_rd = 5'd3; mem_data = 32'h11;
        wb_we  = 1'b1; wb_rd  = 5'd3; wb_data  = 32'h22;
        applyStimulus(1'b1, 5'd3, 5'd3, 32'h33, 32'h44, 32'd0, 1'b0, ALU_OR, 5'd7, 1'b1);
        checkOutput("fwd mem a", alu_a, FWD ? 32'h11 : 32'h33);
        checkOutput("fwd mem b", alu_b, FWD ? 32'h11 : 32'h44);
        mem_we = 1'b0;
        applyStimulus(1'b1, 5'd3, 5'd9, 32'h33, 32'h44, 32'd0, 1'b0, ALU_AND, 5'd7, 1'b1);
        checkOutput("fwd wb a", alu_a, FWD ? 32'h22 : 32'h33);
        mem_we = 1'b1; mem_rd = 5'd0; wb_rd = 5'd0;
        applyStimulus(1'b1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, ALU_ADD, 5'd7, 1'b1);
        checkOutput("fwd x0 a", alu_a, 32'd0);
        mem_we = 1'b0; wb_we = 1'b0;
        idleCycle(1'b1);

        // Backpressure fills the skid; a request while not ready is not taken
        applyStimulus(1'b1, 5'd1, 5'd2, 32'h100, 32'h200, 32'd0, 1'b0, ALU_ADD, 5'd1, 1'b0);
        checkOutput("bp held a", alu_a, 32'h100);
        applyStimulus(1'b1, 5'd1, 5'd2, 32'h300, 32'h400, 32'd0, 1'b0, ALU_XOR, 5'd2, 1'b0);
        checkOutput("bp still a", alu_a, 32'h100);
        checkOutput("bp ready low", {31'd0, in_ready}, 32'd0);
        idleCycle(1'b0);
        applyStimulus(1'b1, 5'd1, 5'd2, 32'h500, 32'h600, 32'd0, 1'b0, ALU_SLT, 5'd3, 1'b1);
        checkOutput("bp second a", alu_a, 32'h300);
        checkOutput("bp second sel", {28'd0, alu_sel}, {28'd0, ALU_XOR});
        checkOutput("bp ready back", {31'd0, in_ready}, 32'd1);
        idleCycle(1'b1);
        checkOutput("bp drained", {31'd0, out_valid}, 32'd0);

        // Held-entry snoop: register operand vs immediate
        applyStimulus(1'b1, 5'd1, 5'd4, 32'd1, 32'h55, 32'd0, 1'b0, ALU_ADD, 5'd8, 1'b0);
        wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'hABCD;
        idleCycle(1'b0);
        checkOutput("snoop reg b", alu_b, FWD ? 32'hABCD : 32'h55);
        wb_we = 1'b0;
        idleCycle(1'b1);
        applyStimulus(1'b1, 5'd1, 5'd4, 32'd1, 32'h55, 32'd8, 1'b1, ALU_ADD, 5'd8, 1'b0);
        wb_we = 1'b1;
        idleCycle(1'b0);
        checkOutput("snoop imm b", alu_b, 32'd8);
        wb_we = 1'b0;
        idleCycle(1'b1);

        // Snoop reaches the skid entry too
        applyStimulus(1'b1, 5'd1, 5'd4, 32'd9, 32'd1, 32'd0, 1'b0, ALU_SRL, 5'd10, 1'b0);
        applyStimulus(1'b1, 5'd2, 5'd4, 32'd9, 32'd2, 32'd0, 1'b0, ALU_SRA, 5'd11, 1'b0);
        wb_we = 1'b1; wb_data = 32'h77;
        idleCycle(1'b0);
        wb_we = 1'b0;
        idleCycle(1'b1);
        checkOutput("snoop skid b", alu_b, FWD ? 32'h77 : 32'd2);
        idleCycle(1'b1);

        // Flush with both entries full and a new request present
        applyStimulus(1'b1, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 1'b0, ALU_ADD, 5'd12, 1'b0);
        applyStimulus(1'b1, 5'd1, 5'd2, 32'd3, 32'd4, 32'd0, 1'b0, ALU_ADD, 5'd13, 1'b0);
        flush = 1'b1;
        applyStimulus(1'b1, 5'd1, 5'd2, 32'd5, 32'd6, 32'd0, 1'b0, ALU_ADD, 5'd14, 1'b0);
        flush = 1'b0;
        checkOutput("flush valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush ready", {31'd0, in_ready}, 32'd1);
        idleCycle(1'b1);
        checkOutput("flush nothing", {31'd0, out_valid}, 32'd0);

        // Mid-stream reset
        applyStimulus(1'b1, 5'd1, 5'd2, 32'h999, 32'h888, 32'd0, 1'b0, ALU_SLTU, 5'd15, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 5'd1, 5'd2, 32'h777, 32'h666, 32'd0, 1'b0, ALU_SLL, 5'd16, 1'b0);
        checkResetPayload();
        rst = 1'b0;
        idleCycle(1'b1);

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
